// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle FETCH/DECODE/execute sequencer; 2 cycles for NOP, 3 otherwise; outputs combinational.
// CU_MEM_WAIT_EN: FETCH, LD_EX and ST_EX stall while mem_rdy=0 (mem_rdy ignored when undefined).
module cpu_control_unit #(
  parameter logic [3:0] ALU_PASS_R = 4'h0,
  parameter logic [3:0] ALU_PASS_S = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR_out,
  input  logic        N,
  input  logic        Z,
  input  logic        carry,
  input  logic        mem_rdy,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic [3:0]  alu_op,
  output logic        s_sel,
  output logic        adr_sel,
  output logic        pc_sel,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        ir_ld,
  output logic        rw_en,
  output logic        mr_en,
  output logic        mw_en,
  output logic        N_flag,
  output logic        Z_flag,
  output logic        C_flag,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH, DECODE, ALU_EX, LD_EX, ST_EX, BR_EX, JMP_EX, HALT
  } state_t;

  state_t     cur_st, nxt_st;
  logic       rdy;
  logic [2:0] cls;
  logic       unused_bits;

`ifdef CU_MEM_WAIT_EN
  assign rdy         = mem_rdy;
  assign unused_bits = ^IR_out[1:0];
`else
  assign rdy         = 1'b1;
  assign unused_bits = ^{IR_out[1:0], mem_rdy};
`endif

  assign cls    = IR_out[14:12];
  assign state  = cur_st;
  assign halted = (cur_st == HALT);

  // Flags only ever move on the ALU_EX exit edge; branches read these, not live N/Z.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_st <= FETCH;
      N_flag <= 1'b0;
      Z_flag <= 1'b0;
      C_flag <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      if (cur_st == ALU_EX) begin
        N_flag <= N;
        Z_flag <= Z;
        C_flag <= carry;
      end
    end
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      FETCH:  if (rdy) nxt_st = DECODE;
      DECODE: begin
        if (IR_out[15]) begin
          nxt_st = ALU_EX;
        end else begin
          case (cls)
            3'b000: nxt_st = FETCH;
            3'b001: nxt_st = LD_EX;
            3'b010: nxt_st = ST_EX;
            3'b011: nxt_st = BR_EX;
            3'b100: nxt_st = BR_EX;
            3'b101: nxt_st = BR_EX;
            3'b110: nxt_st = JMP_EX;
            3'b111: nxt_st = HALT;
          endcase
        end
      end
      ALU_EX: nxt_st = FETCH;
      LD_EX:  if (rdy) nxt_st = FETCH;
      ST_EX:  if (rdy) nxt_st = FETCH;
      BR_EX:  nxt_st = FETCH;
      JMP_EX: nxt_st = FETCH;
      HALT:   nxt_st = HALT;
    endcase
  end

  always_comb begin
    W_Adr   = 3'd0;
    R_Adr   = 3'd0;
    S_Adr   = 3'd0;
    alu_op  = 4'd0;
    s_sel   = 1'b0;
    adr_sel = 1'b0;
    pc_sel  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    ir_ld   = 1'b0;
    rw_en   = 1'b0;
    mr_en   = 1'b0;
    mw_en   = 1'b0;
    case (cur_st)
      FETCH: begin
        mr_en  = 1'b1;
        ir_ld  = rdy;
        pc_inc = rdy;
      end
      ALU_EX: begin
        alu_op = IR_out[14:11];
        W_Adr  = IR_out[10:8];
        R_Adr  = IR_out[7:5];
        S_Adr  = IR_out[4:2];
        rw_en  = 1'b1;
      end
      LD_EX: begin
        adr_sel = 1'b1;
        R_Adr   = IR_out[7:5];
        W_Adr   = IR_out[10:8];
        mr_en   = 1'b1;
        s_sel   = 1'b1;
        rw_en   = rdy;
      end
      ST_EX: begin
        adr_sel = 1'b1;
        R_Adr   = IR_out[7:5];
        S_Adr   = IR_out[4:2];
        alu_op  = ALU_PASS_S;
        mw_en   = 1'b1;
      end
      BR_EX: begin
        case (cls)
          3'b011:  pc_ld = 1'b1;
          3'b100:  pc_ld = Z_flag;
          3'b101:  pc_ld = N_flag;
          default: pc_ld = 1'b0;
        endcase
      end
      JMP_EX: begin
        alu_op = ALU_PASS_R;
        R_Adr  = IR_out[7:5];
        pc_sel = 1'b1;
        pc_ld  = 1'b1;
      end
      default: ;
    endcase
    // State register already sits in FETCH under reset; silence its strobes too.
    if (!reset) begin
      pc_ld  = 1'b0;
      pc_inc = 1'b0;
      ir_ld  = 1'b0;
      rw_en  = 1'b0;
      mr_en  = 1'b0;
      mw_en  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: an instruction-level model predicts every cycle's outputs.
module tb_cpu_control_unit;

  localparam logic [3:0] PASS_R = 4'h0;
  localparam logic [3:0] PASS_S = 4'h1;
`ifdef CU_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] w, r, s;
    logic [3:0] alu;
    logic s_sel, adr_sel, pc_sel, pc_ld, pc_inc, ir_ld, rw_en, mr_en, mw_en;
    logic nf, zf, cf, halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] IR_out = 16'h0000;
  logic        N = 1'b0, Z = 1'b0, carry = 1'b0, mem_rdy = 1'b1;
  logic [2:0]  W_Adr, R_Adr, S_Adr, state;
  logic [3:0]  alu_op;
  logic        s_sel, adr_sel, pc_sel, pc_ld, pc_inc, ir_ld, rw_en, mr_en, mw_en;
  logic        N_flag, Z_flag, C_flag, halted;

  cpu_control_unit #(.ALU_PASS_R(PASS_R), .ALU_PASS_S(PASS_S)) dut (
    .clk(clk), .reset(reset), .IR_out(IR_out), .N(N), .Z(Z), .carry(carry),
    .mem_rdy(mem_rdy), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .alu_op(alu_op), .s_sel(s_sel), .adr_sel(adr_sel), .pc_sel(pc_sel),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld), .rw_en(rw_en),
    .mr_en(mr_en), .mw_en(mw_en), .N_flag(N_flag), .Z_flag(Z_flag),
    .C_flag(C_flag), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  exp_now = '0;
  exp_t  last_act = '0;
  exp_t  exec_act = '0;
  bit    exp_vld = 1'b0;
  string tag = "";
  logic  mf_n = 1'b0, mf_z = 1'b0, mf_c = 1'b0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask

  // Sampled mid-cycle, away from the rising edge where inputs change.
  always @(negedge clk) begin
    exp_t act;
    act = {W_Adr, R_Adr, S_Adr, alu_op, s_sel, adr_sel, pc_sel, pc_ld, pc_inc,
           ir_ld, rw_en, mr_en, mw_en, N_flag, Z_flag, C_flag, halted};
    last_act = act;
    if (exp_vld) chk({"cyc_", tag}, 32'(act), 32'(exp_now));
  end

  function automatic exp_t base();
    exp_t e = '0;
    e.nf = mf_n;
    e.zf = mf_z;
    e.cf = mf_c;
    return e;
  endfunction

  task automatic cyc(input string t, input exp_t e);
    tag = t;
    exp_now = e;
    exp_vld = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    N = 1'($urandom);
    Z = 1'($urandom);
    carry = 1'($urandom);
  endtask

  // mem_rdy pattern: with waits, stays low for 'waits' cycles then high (ignored without the wait build).
  function automatic logic rdy_at(input int k, input int nw, input int waits);
    if (WAIT_EN) return (k == nw);
    return (waits == 0);
  endfunction

  task automatic fetch_decode(input logic [15:0] ir, input int waits);
    exp_t e;
    int nw;
    nw = WAIT_EN ? waits : 0;
    for (int k = 0; k <= nw; k++) begin
      mem_rdy = rdy_at(k, nw, waits);
      noise();
      e = base();
      e.mr_en = 1'b1;
      e.ir_ld = mem_rdy | !WAIT_EN;
      e.pc_inc = e.ir_ld;
      cyc("fetch", e);
    end
    IR_out = ir;
    mem_rdy = 1'b1;
    noise();
    cyc("decode", base());
  endtask

  task automatic do_instr(input logic [15:0] ir, input logic n_i, input logic z_i,
                          input logic c_i, input int waits);
    exp_t e;
    int nw;
    logic [2:0] cls;
    nw = WAIT_EN ? waits : 0;
    cls = ir[14:12];
    fetch_decode(ir, waits);
    if (ir[15]) begin
      N = n_i; Z = z_i; carry = c_i;
      e = base();
      e.w = ir[10:8]; e.r = ir[7:5]; e.s = ir[4:2]; e.alu = ir[14:11]; e.rw_en = 1'b1;
      cyc("alu_ex", e);
      mf_n = n_i; mf_z = z_i; mf_c = c_i;
    end else if (cls == 3'b001 || cls == 3'b010) begin
      for (int k = 0; k <= nw; k++) begin
        mem_rdy = rdy_at(k, nw, waits);
        noise();
        e = base();
        e.adr_sel = 1'b1;
        e.r = ir[7:5];
        if (cls == 3'b001) begin
          e.mr_en = 1'b1; e.s_sel = 1'b1; e.w = ir[10:8];
          e.rw_en = mem_rdy | !WAIT_EN;
          cyc("ld_ex", e);
        end else begin
          e.s = ir[4:2]; e.alu = PASS_S; e.mw_en = 1'b1;
          cyc("st_ex", e);
        end
      end
      mem_rdy = 1'b1;
    end else if (cls >= 3'b011 && cls <= 3'b101) begin
      noise();
      e = base();
      e.pc_ld = (cls == 3'b011) || (cls == 3'b100 && mf_z) || (cls == 3'b101 && mf_n);
      cyc("br_ex", e);
    end else if (cls == 3'b110) begin
      e = base();
      e.alu = PASS_R; e.r = ir[7:5]; e.pc_sel = 1'b1; e.pc_ld = 1'b1;
      cyc("jmp_ex", e);
    end else if (cls == 3'b111) begin
      for (int k = 0; k < 20; k++) begin
        noise();
        mem_rdy = 1'(k % 2);
        e = base();
        e.halted = 1'b1;
        cyc("halt", e);
      end
      mem_rdy = 1'b1;
    end
    exec_act = last_act;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    mf_n = 1'b0; mf_z = 1'b0; mf_c = 1'b0;
    cyc("in_reset", base());
    reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    @(posedge clk); #1;
    cyc("reset0", base());
    reset_pulse();

    // ALU op 0x8A70 with Z=1
    do_instr(16'h8A70, 1'b0, 1'b1, 1'b0, 0);
    chk("alu_w", 32'(exec_act.w), 2);
    chk("alu_r", 32'(exec_act.r), 3);
    chk("alu_s", 32'(exec_act.s), 4);
    chk("alu_op", 32'(exec_act.alu), 1);
    chk("alu_rw_en", 32'(exec_act.rw_en), 1);
    chk("alu_s_sel", 32'(exec_act.s_sel), 0);
    chk("zflag_after_alu", 32'(Z_flag), 1);

    do_instr(16'h4005, 1'b0, 1'b0, 1'b0, 0);
    chk("bz_taken_pc_ld", 32'(exec_act.pc_ld), 1);
    chk("bz_taken_pc_sel", 32'(exec_act.pc_sel), 0);

    do_instr(16'hB1E4, 1'b1, 1'b0, 1'b1, 0);
    do_instr(16'h4005, 1'b0, 1'b0, 1'b0, 0);
    chk("bz_not_taken_pc_ld", 32'(exec_act.pc_ld), 0);
    do_instr(16'h5005, 1'b0, 1'b0, 1'b0, 0);
    chk("bn_taken_pc_ld", 32'(exec_act.pc_ld), 1);
    do_instr(16'h3080, 1'b0, 1'b0, 1'b0, 0);
    chk("br_pc_ld", 32'(exec_act.pc_ld), 1);

    do_instr(16'h1140, 1'b0, 1'b0, 1'b0, 3);
    chk("ld_adr_sel", 32'(exec_act.adr_sel), 1);
    chk("ld_r", 32'(exec_act.r), 2);
    chk("ld_mr_en", 32'(exec_act.mr_en), 1);
    chk("ld_rw_en", 32'(exec_act.rw_en), 1);
    chk("ld_w", 32'(exec_act.w), 1);

    do_instr(16'h20B8, 1'b0, 1'b0, 1'b0, 2);
    chk("st_mw_en", 32'(exec_act.mw_en), 1);
    chk("st_alu", 32'(exec_act.alu), 1);
    chk("st_r", 32'(exec_act.r), 5);
    chk("st_s", 32'(exec_act.s), 6);

    do_instr(16'h6040, 1'b0, 1'b0, 1'b0, 0);
    chk("jmp_alu", 32'(exec_act.alu), 0);
    chk("jmp_r", 32'(exec_act.r), 2);
    chk("jmp_pc_sel", 32'(exec_act.pc_sel), 1);
    chk("jmp_pc_ld", 32'(exec_act.pc_ld), 1);
    chk("jmp_pc_inc", 32'(exec_act.pc_inc), 0);

    do_instr(16'h0000, 1'b0, 1'b0, 1'b0, 0);

    // Reset pulled low in the middle of ALU_EX with all flags set
    do_instr(16'h8A70, 1'b1, 1'b1, 1'b1, 0);
    fetch_decode(16'h9C94, 0);
    exp_vld = 1'b0;
    #1 reset = 1'b0;
    mf_n = 1'b0; mf_z = 1'b0; mf_c = 1'b0;
    #1;
    chk("rst_alu_strobes", 32'({pc_ld, pc_inc, ir_ld, rw_en, mr_en, mw_en}), 0);
    chk("rst_alu_flags", 32'({N_flag, Z_flag, C_flag}), 0);
    cyc("rst_in_alu", base());
    reset = 1'b1;
    #1;
    chk("post_rst_ir_ld", 32'(ir_ld), 1);
    chk("post_rst_pc_inc", 32'(pc_inc), 1);
    do_instr(16'h0000, 1'b0, 1'b0, 1'b0, 0);

    do_instr(16'h7000, 1'b0, 1'b0, 1'b0, 0);
    chk("halt_halted", 32'(exec_act.halted), 1);
    reset_pulse();
    do_instr(16'h0000, 1'b0, 1'b0, 1'b0, 0);
    chk("halt_left", 32'(halted), 0);

    exp_vld = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Control unit for the 16-bit RISC processor: a multi-cycle FSM that pairs with the integer execution unit and drives every control input that unit consumes (register addresses, ALU op, mux selects, PC/IR load strobes, register write enable). It consumes the unit's `IR_out`, `N`, `Z` and `carry`. It also drives memory read/write strobes. It sequences each instruction as FETCH, DECODE, then one execute state.

## Interface
- `ALU_PASS_R`, default 4'h0: ALU op code that passes the R operand to `Alu_out`.
- `ALU_PASS_S`, default 4'h1: ALU op code that passes the S operand to `Alu_out`.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `IR_out` in 16: current instruction from the execution unit's IR.
- `N`, `Z`, `carry` in 1 each: ALU flags from the execution unit.
- `mem_rdy` in 1: memory ready. It is used only when `CU_MEM_WAIT_EN` is defined.
- `W_Adr`, `R_Adr`, `S_Adr` out 3 each: register write, R-read and S-read addresses.
- `alu_op` out 4: ALU operation select.
- `s_sel`, `adr_sel`, `pc_sel` out 1 each: datapath mux selects.
- `pc_ld`, `pc_inc`, `ir_ld`, `rw_en` out 1 each: load, increment and write strobes.
- `mr_en`, `mw_en` out 1 each: memory read and write strobes.
- `N_flag`, `Z_flag`, `C_flag` out 1 each: latched status flags.
- `halted` out 1: high while the FSM is in HALT.
- `state` out 3: current FSM state, for debug.

## Operation
- Instruction encoding:
  - `IR_out[15]`=1 is an ALU register op: `alu_op`=IR[14:11], W=IR[10:8], R=IR[7:5], S=IR[4:2].
  - `IR_out[15]`=0 selects a class from IR[14:12]: 000 NOP, 001 LD, 010 ST, 011 BR, 100 BZ, 101 BN, 110 JMP, 111 HALT.
  - LD: W=IR[10:8], address register R=IR[7:5].
  - ST: address register R=IR[7:5], data register S=IR[4:2].
  - BR, BZ, BN: 8-bit offset IR[7:0]. The execution unit applies it relative to the already-incremented PC.
  - JMP: R=IR[7:5].
- FSM states:
  - FETCH: `adr_sel`=0, `mr_en`=1, `ir_ld`=1, `pc_inc`=1. Goes to DECODE.
  - DECODE: no strobes. Goes to the execute state for the instruction class.
  - ALU_EX: `rw_en`=1, `s_sel`=0, W, R and S addresses driven from IR. `N_flag`, `Z_flag` and `C_flag` capture `N`, `Z` and `carry` on the exit edge.
  - LD_EX: `adr_sel`=1, `R_Adr`=addr reg, `mr_en`=1, `s_sel`=1, `rw_en`=1, `W_Adr`=W.
  - ST_EX: `adr_sel`=1, `R_Adr`=addr reg, `S_Adr`=data reg, `alu_op`=`ALU_PASS_S`, `mw_en`=1.
  - BR_EX: `pc_sel`=0. `pc_ld`=1 for BR always, for BZ when `Z_flag`=1, and for BN when `N_flag`=1.
  - JMP_EX: `alu_op`=`ALU_PASS_R`, `R_Adr`=R, `pc_sel`=1, `pc_ld`=1.
  - HALT: all strobes 0, `halted`=1. Left only by reset.
- NOP executes in DECODE and returns to FETCH.
- All execute states return to FETCH.
- Outputs are combinational functions of the current state and `IR_out`.
- Every strobe not listed for a state is 0. Addresses and `alu_op` are 0 where they are unused.
- `pc_ld` and `pc_inc` are never both 1 in the same cycle.
- The status flags change only in ALU_EX. LD, ST and branches leave them unchanged.

## Timing
- While `reset` is low:
  - `state` = FETCH.
  - `N_flag`, `Z_flag` and `C_flag` = 0, and `halted` = 0.
  - All strobes are forced to 0 combinationally.
- Reset assertion takes effect immediately in any state, including in the middle of an execute state or a wait.
- The first FETCH occurs on the first rising edge after `reset` goes high.
- Cycles per instruction with zero wait: 2 for NOP, 3 for all others. HALT is entered after 2 cycles.
- The IR updates on the FETCH exit edge. DECODE sees the new `IR_out`.
- A branch condition uses flags latched by an earlier ALU instruction, never the live `N` or `Z`.

## Configuration
- `CU_MEM_WAIT_EN` defined:
  - FETCH, LD_EX and ST_EX hold while `mem_rdy`=0.
  - `mr_en` or `mw_en` and `adr_sel` stay asserted during the hold.
  - `ir_ld`, `pc_inc` and `rw_en` are gated by `mem_rdy`. They pulse only in the cycle where `mem_rdy`=1, and the state advances on that edge.
- `CU_MEM_WAIT_EN` undefined: `mem_rdy` is ignored (treated as 1) and every state takes one cycle.

## Test plan
- Reset pulled low during ALU_EX → all strobes 0 at once, flags 0. After release, the next cycle is FETCH with `ir_ld`=1 and `pc_inc`=1.
- IR=0x8A70 → in ALU_EX: `rw_en`=1, `W_Adr`=2, `R_Adr`=3, `S_Adr`=4, `alu_op`=1, `s_sel`=0. With `Z`=1 during that cycle, `Z_flag`=1 afterwards.
- IR=0x4005 with `Z_flag`=1 → BR_EX shows `pc_ld`=1, `pc_sel`=0. Same IR with `Z_flag`=0 → `pc_ld`=0, then FETCH.
- IR=0x1140 with the macro defined and `mem_rdy` low for 3 cycles → LD_EX lasts 4 cycles with `adr_sel`=1, `R_Adr`=2, `mr_en`=1. `rw_en`=1 with `W_Adr`=1 only in the 4th cycle.
- IR=0x6040 → JMP_EX shows `alu_op`=`ALU_PASS_R`, `R_Adr`=2, `pc_sel`=1, `pc_ld`=1, `pc_inc`=0.
- IR=0x7000 → `halted`=1 and no strobes for 20 cycles. A reset pulse returns the FSM to FETCH.
